bit_debouncer: RTL and testbench

BIT_DEBOUNCER -- requirements
Module: bit_debouncer

---
 rtl/debounce_pkg.sv | 19 +
 rtl/bit_debouncer_edge_counter.sv | 20 ++
 rtl/bit_debouncer.sv | 103 ++++++++++
 tb/tb_bit_debouncer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the bit debouncer and its edge counter.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        PEND_HIGH = 2'd1,
        ST_HIGH   = 2'd2,
        PEND_LOW  = 2'd3
    } state_t;

    localparam int DEFAULT_STABLE_CYCLES = 4;
    localparam int DEFAULT_CNT_W         = 8;

    // Width of a counter that must reach n-1; never below one bit.
    function automatic int stab_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_debouncer_edge_counter.sv
// Free-running wrap-around counter of debounced edges.
module edge_counter
    import debounce_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/bit_debouncer.sv
// Four-state debouncer with registered level, edge pulses and optional edge
// counter built only when BIT_DEBOUNCER_EDGE_COUNT_EN is defined.
module bit_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    output logic             q,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int             SW        = stab_width(STABLE_CYCLES);
    localparam logic [SW-1:0]  STAB_LAST = SW'(STABLE_CYCLES - 1);

    state_t        state;
    logic [SW-1:0] stab_cnt;

    // stab_cnt counts samples that disagree with q; the first one is taken in the ST_* state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_LOW;
            stab_cnt   <= '0;
            q          <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                ST_LOW: begin
                    if (d) begin
                        state    <= PEND_HIGH;
                        stab_cnt <= SW'(1);
                    end else begin
                        stab_cnt <= '0;
                    end
                end
                PEND_HIGH: begin
                    if (!d) begin
                        state    <= ST_LOW;
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state      <= ST_HIGH;
                        stab_cnt   <= '0;
                        q          <= 1'b1;
                        rise_pulse <= 1'b1;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!d) begin
                        state    <= PEND_LOW;
                        stab_cnt <= SW'(1);
                    end else begin
                        stab_cnt <= '0;
                    end
                end
                PEND_LOW: begin
                    if (d) begin
                        state    <= ST_HIGH;
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_LAST) begin
                        state      <= ST_LOW;
                        stab_cnt   <= '0;
                        q          <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_LOW;
                    stab_cnt <= '0;
                    q        <= 1'b0;
                end
            endcase
        end
    end

`ifdef BIT_DEBOUNCER_EDGE_COUNT_EN
    logic edge_inc;
    assign edge_inc = rise_pulse | fall_pulse;

    edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk (clk),
        .rst (rst),
        .inc (edge_inc),
        .cnt (edge_cnt)
    );
`else
    assign edge_cnt = '0;
`endif

endmodule

// File: tb/tb_bit_debouncer.sv
// Scoreboard bench for bit_debouncer: a run-length reference model pushes
// expectations on each rising edge, the checker pops them on the falling edge.
module tb_bit_debouncer;

    localparam int STABLE = 4;

`ifdef BIT_DEBOUNCER_EDGE_COUNT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    typedef struct packed {
        logic       q;
        logic       rise;
        logic       fall;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       d;
    logic       q, rise_pulse, fall_pulse;
    logic [7:0] edge_cnt;
    logic       q2, rise2, fall2;
    logic [1:0] edge_cnt2;

    int total = 0;
    int bad   = 0;
    int npulse = 0;

    exp_t exp_q[$];
    exp_t e_push, e_pop;

    logic       mq, mr, mf;
    int         run;
    logic [7:0] mcnt;

    always #3 clk = ~clk;

    bit_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .q          (q),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .edge_cnt   (edge_cnt)
    );

    bit_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(2)) dut_w2 (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .q          (q2),
        .rise_pulse (rise2),
        .fall_pulse (fall2),
        .edge_cnt   (edge_cnt2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: count consecutive samples differing from the debounced level.
    always @(posedge clk) begin
        if (rst) begin
            mq = 1'b0; mr = 1'b0; mf = 1'b0; run = 0; mcnt = '0;
        end else begin
            if (mr || mf) mcnt = mcnt + 8'd1;
            mr = 1'b0;
            mf = 1'b0;
            if (d != mq) run = run + 1;
            else         run = 0;
            if (run == STABLE) begin
                mq  = d;
                run = 0;
                if (d) mr = 1'b1;
                else   mf = 1'b1;
            end
        end
        e_push.q    = mq;
        e_push.rise = mr;
        e_push.fall = mf;
        e_push.cnt  = EDGE_EN ? mcnt : 8'd0;
        e_push.cnt2 = EDGE_EN ? mcnt[1:0] : 2'd0;
        exp_q.push_back(e_push);
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_pop = exp_q.pop_front();
            check_val("q",        32'(q),          32'(e_pop.q));
            check_val("rise",     32'(rise_pulse), 32'(e_pop.rise));
            check_val("fall",     32'(fall_pulse), 32'(e_pop.fall));
            check_val("edge_cnt", 32'(edge_cnt),   32'(e_pop.cnt));
            check_val("w2_q",     32'(q2),         32'(e_pop.q));
            check_val("w2_cnt",   32'(edge_cnt2),  32'(e_pop.cnt2));
            check_val("excl",     32'(rise_pulse & fall_pulse), 32'd0);
            if (rise_pulse || fall_pulse) npulse++;
        end
    end

    // Drive d, then return just after the falling edge that follows its sample.
    task automatic tick(input logic dv);
        d = dv;
        @(negedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_q"},    32'(q),          32'd0);
        check_val({tag, "_rise"}, 32'(rise_pulse), 32'd0);
        check_val({tag, "_fall"}, 32'(fall_pulse), 32'd0);
        check_val({tag, "_cnt"},  32'(edge_cnt),   32'd0);
    endtask

    int p0;

    initial begin
        rst = 1'b1;
        d   = 1'b0;
        #1 check_zero("rst_t1");
        #1 d = 1'b1;
        #2 check_zero("rst_t4");
        #1 d = 1'b0;
        #3 d = 1'b1;
        #2 begin rst = 1'b0; d = 1'b0; end
        @(negedge clk); #1;

        // Three high samples then low: no change.
        repeat (3) tick(1'b1);
        repeat (2) tick(1'b0);
        check_val("glitch_q", 32'(q), 32'd0);

        // Clean rise: pulse on the fourth consecutive sample.
        repeat (6) tick(1'b1);
        check_val("rise_q", 32'(q), 32'd1);

        // Slow toggle every 5 cycles: one pulse per d change.
        p0 = npulse;
        for (int i = 0; i < 5; i++)
            repeat (5) tick((i % 2) == 1);
        check_val("slow_pulses", 32'(npulse - p0), 32'd5);
        check_val("slow_q", 32'(q), 32'd0);

        // Fast toggle: q never moves.
        for (int i = 0; i < 20; i++) tick((i % 2) == 0);
        check_val("fast_q", 32'(q), 32'd0);
        repeat (2) tick(1'b0);

        // Reset while two samples into PEND_HIGH.
        repeat (2) tick(1'b1);
        rst = 1'b1;
        #1 check_zero("midpend");
        check_val("midpend_w2", 32'(edge_cnt2), 32'd0);
        tick(1'b1);
        rst = 1'b0;
        repeat (6) tick(1'b1);
        check_val("post_rst_q", 32'(q), 32'd1);
        repeat (2) tick(1'b0);

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
